opram_wr_queue: RTL and testbench

- Write-side front end for the 32-entry x 2-bit multi-read operand RAM (opram_32x2).
- That RAM has one write port, but rename allocation and writeback can each produce a write in the same cycle.
- This block accepts up to two write requests per cycle, buffers them in order, and drains exactly one per cycle into the RAM write port (WEN/AW/DI).
- It also forwards still-queued values to the RAM's read ports, so readers always see the newest value for each address.

---
 rtl/opram_wr_queue.sv | 106 ++++++++++
 tb/tb_opram_wr_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/opram_wr_queue.sv
// opram_wr_queue: write-side front end for the 32x2 multi-read operand RAM.
// Accepts up to two in-order write requests per cycle, drains one per cycle
// onto the RAM write port and forwards still-queued data to the read ports.
module opram_wr_queue #(
   parameter int DEPTH = 4,
   parameter int NRD   = 7
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       in0_valid,
   input  logic [4:0]                 in0_addr,
   input  logic [1:0]                 in0_data,
   input  logic                       in1_valid,
   input  logic [4:0]                 in1_addr,
   input  logic [1:0]                 in1_data,
   output logic                       in_ready,
   output logic                       WEN,
   output logic [4:0]                 AW,
   output logic [1:0]                 DI,
   input  logic [NRD*5-1:0]           rd_addr,
   output logic [NRD-1:0]             fwd_hit,
   output logic [NRD*2-1:0]           fwd_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]    r_addr [DEPTH];
   logic [1:0]    r_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic          w_ready;
   logic          w_push0;
   logic          w_push1;
   logic          w_pop;
   logic [PW-1:0] w_slot1;
   logic [CW-1:0] w_npush;

   // Readiness comes from registered occupancy only; pushes while not ready are dropped.
   assign w_ready = (r_count <= CW'(DEPTH - 2));
   assign w_push0 = in0_valid & w_ready;
   assign w_push1 = in1_valid & w_ready;
   assign w_pop   = (r_count != '0);
   assign w_slot1 = w_push0 ? (r_tail + PW'(1)) : r_tail;
   assign w_npush = CW'(w_push0) + CW'(w_push1);

   assign in_ready = w_ready;
   assign count    = r_count;
   assign WEN      = w_pop;
   assign AW       = w_pop ? r_addr[r_head] : '0;
   assign DI       = w_pop ? r_data[r_head] : '0;

   // Entry storage: in0 lands at tail, in1 behind it; popped entries are left in place.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (w_push0) begin
            r_addr[r_tail] <= in0_addr;
            r_data[r_tail] <= in0_data;
         end
         if (w_push1) begin
            r_addr[w_slot1] <= in1_addr;
            r_data[w_slot1] <= in1_data;
         end
      end
   end

   // Head, tail and occupancy; reset discards everything queued.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PW'(w_pop);
         r_tail  <= r_tail + PW'(w_npush);
         r_count <= r_count + w_npush - CW'(w_pop);
      end
   end

   // Forwarding: scan occupied entries oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) &&
                (r_addr[r_head + PW'(k)] == rd_addr[5*i +: 5])) begin
               fwd_hit[i]          = 1'b1;
               fwd_data[2*i +: 2]  = r_data[r_head + PW'(k)];
            end
         end
      end
   end

   // Flag producers that push while the queue is not ready.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (!((in0_valid || in1_valid) && !w_ready))
            else $error("opram_wr_queue: push while in_ready=0 dropped");
      end
   end

endmodule

// File: tb/tb_opram_wr_queue.sv
// Self-checking bench for opram_wr_queue: a queue scoreboard models the
// buffered writes; outputs are compared on the falling edge.
module tb_opram_wr_queue;

   localparam int DEPTH = 4;
   localparam int NRD   = 7;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              in0_valid = 1'b0;
   logic [4:0]        in0_addr  = '0;
   logic [1:0]        in0_data  = '0;
   logic              in1_valid = 1'b0;
   logic [4:0]        in1_addr  = '0;
   logic [1:0]        in1_data  = '0;
   logic              in_ready;
   logic              WEN;
   logic [4:0]        AW;
   logic [1:0]        DI;
   logic [NRD*5-1:0]  rd_addr = '0;
   logic [NRD-1:0]    fwd_hit;
   logic [NRD*2-1:0]  fwd_data;
   logic [$clog2(DEPTH):0] count;

   opram_wr_queue #(.DEPTH(DEPTH), .NRD(NRD)) dut (
      .CLK(CLK), .RST(RST),
      .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data),
      .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
      .in_ready(in_ready), .WEN(WEN), .AW(AW), .DI(DI),
      .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .count(count)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [4:0] a;
      logic [1:0] d;
   } ent_t;

   ent_t        q[$];
   logic [1:0]  ram [32];
   int          n_checks = 0;
   int          n_errors = 0;
   bit          armed    = 1'b0;
   bit          fixed_rd = 1'b0;
   int          pin0     = -1;
   int          max_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic       eh;
      logic [1:0] ed;
      chk("rdy", 32'(in_ready), 32'(q.size() <= DEPTH - 2));
      chk("cnt", 32'(count), 32'(q.size()));
      chk("wen", 32'(WEN), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("aw", 32'(AW), 32'(q[0].a));
         chk("di", 32'(DI), 32'(q[0].d));
      end else begin
         chk("aw0", 32'(AW), 32'd0);
         chk("di0", 32'(DI), 32'd0);
      end
      for (int i = 0; i < NRD; i++) begin
         eh = 1'b0;
         ed = 2'b00;
         foreach (q[k]) begin
            if (q[k].a == rd_addr[5*i +: 5]) begin
               eh = 1'b1;
               ed = q[k].d;
            end
         end
         chk($sformatf("hit%0d", i), 32'(fwd_hit[i]), 32'(eh));
         chk($sformatf("fdat%0d", i), 32'(fwd_data[2*i +: 2]), 32'(ed));
      end
      if (WEN) ram[AW] = DI;
      if (int'(count) > max_cnt) max_cnt = int'(count);
   endtask

   task automatic step(input logic rst,
                       input logic v0, input logic [4:0] a0, input logic [1:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [1:0] d1);
      bit exp_ready;
      RST       = rst;
      in0_valid = v0; in0_addr = a0; in0_data = d0;
      in1_valid = v1; in1_addr = a1; in1_data = d1;
      if (!fixed_rd) begin
         for (int i = 0; i < NRD; i++) rd_addr[5*i +: 5] = 5'($urandom_range(0, 15));
         if (pin0 >= 0) rd_addr[4:0] = 5'(pin0);
      end
      @(negedge CLK);
      if (armed) check_outputs();
      @(posedge CLK);
      if (rst) begin
         q.delete();
         armed = 1'b1;
      end else begin
         exp_ready = (q.size() <= DEPTH - 2);
         if (q.size() != 0) void'(q.pop_front());
         if (exp_ready) begin
            if (v0) q.push_back('{a: a0, d: d0});
            if (v1) q.push_back('{a: a1, d: d1});
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 2'b00;

      // Reset and idle
      step(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
      step(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
      idle(2);

      // Single write, forwarded on port 0
      pin0 = 5;
      step(1'b0, 1'b1, 5'd5, 2'b11, 1'b0, 5'd0, 2'd0);
      idle(2);

      // Dual write to the same address: in1 is younger
      pin0 = 7;
      step(1'b0, 1'b1, 5'd7, 2'b01, 1'b1, 5'd7, 2'b10);
      idle(3);
      chk("ram7", 32'(ram[7]), 32'd2);
      pin0 = -1;

      // Backpressure: two pairs back to back
      max_cnt = 0;
      step(1'b0, 1'b1, 5'd10, 2'd0, 1'b1, 5'd11, 2'd1);
      step(1'b0, 1'b1, 5'd12, 2'd2, 1'b1, 5'd13, 2'd3);
      idle(5);
      chk("bp_max", 32'(max_cnt), 32'd3);

      // Wrap-around: ten single writes, one per cycle
      max_cnt = 0;
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b1, 5'(i), 2'($urandom_range(0, 3)), 1'b0, 5'd0, 2'd0);
      idle(2);
      chk("wrap_max", 32'(max_cnt), 32'd1);
      fixed_rd = 1'b1;
      for (int i = 0; i < NRD; i++) rd_addr[5*i +: 5] = 5'(i);
      idle(1);
      for (int i = 0; i < NRD; i++) rd_addr[5*i +: 5] = 5'(7 + (i % 3));
      idle(1);
      fixed_rd = 1'b0;

      // Reset while three entries are queued, with a dual push
      step(1'b0, 1'b1, 5'd20, 2'd1, 1'b1, 5'd21, 2'd2);
      step(1'b0, 1'b1, 5'd22, 2'd3, 1'b1, 5'd23, 2'd0);
      step(1'b1, 1'b1, 5'd24, 2'd1, 1'b1, 5'd25, 2'd2);
      idle(3);

      // Random traffic on a small address set, respecting readiness
      for (int n = 0; n < 60; n++) begin
         if (q.size() <= DEPTH - 2)
            step(1'b0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         else
            idle(1);
      end
      idle(5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
